pipe_stage_elastic: RTL and testbench

- Parametrised successor to the fixed MEM/WB-style pipe register.
- Implements a DEPTH-stage elastic pipeline register with:
  - valid/ready handshaking on both sides
  - bubble collapsing
  - synchronous flush
- Control bits are forced to zero whenever a stage is empty or flushed. Data bits are held.
- Any pipe boundary in the core can use it where stalls, flushes and multi-cycle retiming are needed.

---
 rtl/pipe_stage_elastic.sv | 130 +++++++++++++
 tb/tb_pipe_stage_elastic.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// DEPTH-stage elastic pipe register with valid/ready handshakes, bubble collapse and synchronous flush.
// Optional saturating downstream-stall counter on o_stall_cnt when PIPE_STAGE_STALL_CNT_EN is defined.
module pipe_stage_elastic #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 4,
    parameter int DEPTH  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [CTRL_W-1:0]            i_ctrl,
    input  logic [DATA_W-1:0]            i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [CTRL_W-1:0]            o_ctrl,
    output logic [DATA_W-1:0]            o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [15:0]                  o_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("pipe_stage_elastic: DEPTH must be in 1..8");
    end

    logic [DEPTH-1:0]             v_q, v_d;
    logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [DEPTH-1:0]             rdy;

    // Source of stage k is entry k: index 0 is the upstream port, index k>0 is stage k-1.
    logic [DEPTH:0]               src_v;
    logic [DEPTH:0][CTRL_W-1:0]   src_ctrl;
    logic [DEPTH:0][DATA_W-1:0]   src_data;

    assign src_v    = {v_q, i_valid};
    assign src_ctrl = {ctrl_q, i_ctrl};
    assign src_data = {data_q, i_data};

    // A stage can take a new entry if it is empty or anything downstream of it will move.
    always_comb begin : ready_chain
        logic r;
        r   = i_ready;
        rdy = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            r      = ~v_q[k] | r;
            rdy[k] = r;
        end
    end

    assign o_ready = rdy[0] & ~clear;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        v_d     = v_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        count_d = '0;
        if (clear) begin
            v_d    = '0;
            ctrl_d = '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    v_d[k] = src_v[k];
                    if (src_v[k]) begin
                        ctrl_d[k] = src_ctrl[k];
                        data_d[k] = src_data[k];
                    end else begin
                        ctrl_d[k] = '0;
                    end
                end
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            count_d = count_d + CNT_W'(v_d[k]);
        end
    end

    // NOTE: the payload registers are reset too, because o_data must read zero out of reset;
    // flush deliberately leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= '0;
            ctrl_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
            v_q     <= v_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign o_valid = v_q[DEPTH-1];
    assign o_ctrl  = ctrl_q[DEPTH-1];
    assign o_data  = data_q[DEPTH-1];
    assign o_count = count_q;

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (o_valid && !i_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign o_stall_cnt = stall_q;
`endif

    // Downstream must see a stalled output held, and control bits never leak from an empty stage.
    a_hold_on_stall : assert property (@(posedge clk) disable iff (rst)
        (o_valid && !i_ready && !clear) |=> (o_valid && $stable(o_data) && $stable(o_ctrl)));

    a_ctrl_zero_empty : assert property (@(posedge clk) disable iff (rst)
        !o_valid |-> (o_ctrl == '0));

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Randomized bench for pipe_stage_elastic (DEPTH=3) against a position-based queue model.
// Define PIPE_STAGE_STALL_CNT_EN to also check o_stall_cnt.
module tb_pipe_stage_elastic;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 4;
    localparam int DEPTH  = 3;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic [CTRL_W-1:0] i_ctrl = '0;
    logic [DATA_W-1:0] i_data = '0;
    logic              o_valid;
    logic              i_ready = 1'b0;
    logic [CTRL_W-1:0] o_ctrl;
    logic [DATA_W-1:0] o_data;
    logic [CNT_W-1:0]  o_count;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0]       o_stall_cnt;
`endif

    pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_ctrl  (i_ctrl),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_ctrl  (o_ctrl),
        .o_data  (o_data),
        .o_count (o_count)
`ifdef PIPE_STAGE_STALL_CNT_EN
        ,
        .o_stall_cnt (o_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: entries in arrival order, each with its stage position (DEPTH-1 = output).
    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        int                pos;
    } entry_t;

    entry_t      mq[$];
    logic [15:0] m_last  = '0;
    int unsigned m_stall = 0;

    function automatic bit m_valid();
        return mq.size() > 0 && mq[0].pos == DEPTH - 1;
    endfunction

    function automatic bit m_ready(input logic clr, input logic ird);
        return !clr && (ird || mq.size() < DEPTH);
    endfunction

    function automatic logic [CTRL_W-1:0] m_ctrl();
        if (m_valid()) return mq[0].ctrl;
        return '0;
    endfunction

    // An entry moves forward if the output drains, or if the slots ahead of it
    // outnumber the entries ahead of it (a bubble exists).
    task automatic model_edge(input logic iv, input logic [CTRL_W-1:0] ictrl,
                              input logic [DATA_W-1:0] idata, input logic ird, input logic clr);
        bit accept;
        accept = iv && m_ready(clr, ird);
        if (m_valid() && !ird && m_stall != 32'hFFFF) m_stall++;
        if (clr) begin
            mq.delete();
            return;
        end
        for (int i = 0; i < mq.size(); i++) begin
            entry_t e;
            e = mq[i];
            if (ird || (DEPTH - 1 - e.pos) > i) begin
                e.pos = e.pos + 1;
                if (e.pos == DEPTH - 1) m_last = e.data;
            end
            mq[i] = e;
        end
        if (mq.size() > 0 && mq[0].pos == DEPTH) void'(mq.pop_front());
        if (accept) begin
            entry_t n;
            n.ctrl = ictrl;
            n.data = idata;
            n.pos  = 0;
            mq.push_back(n);
            if (DEPTH == 1) m_last = idata;
        end
    endtask

    task automatic check_outputs();
        check("o_valid", {31'd0, o_valid}, {31'd0, m_valid()});
        check("o_ctrl", 32'(o_ctrl), 32'(m_ctrl()));
        check("o_data", 32'(o_data), 32'(m_last));
        check("o_count", 32'(o_count), 32'(mq.size()));
`ifdef PIPE_STAGE_STALL_CNT_EN
        check("o_stall_cnt", 32'(o_stall_cnt), m_stall);
`endif
    endtask

    // One clock: drive at negedge, check just after, then step the model on the posedge.
    task automatic cycle(input logic iv, input logic [CTRL_W-1:0] ictrl,
                         input logic [DATA_W-1:0] idata, input logic ird, input logic clr);
        @(negedge clk);
        i_valid = iv;
        i_ctrl  = ictrl;
        i_data  = idata;
        i_ready = ird;
        clear   = clr;
        #1;
        check("o_ready", {31'd0, o_ready}, {31'd0, m_ready(clr, ird)});
        check_outputs();
        @(posedge clk);
        model_edge(iv, ictrl, idata, ird, clr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = 16'hBEEF;
        i_ctrl  = 4'hF;
        i_ready = 1'($urandom);
        clear   = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_o_valid", {31'd0, o_valid}, 32'd0);
        check("rst_o_ctrl", 32'(o_ctrl), 32'd0);
        check("rst_o_data", 32'(o_data), 32'd0);
        check("rst_o_count", 32'(o_count), 32'd0);
`ifdef PIPE_STAGE_STALL_CNT_EN
        check("rst_o_stall_cnt", 32'(o_stall_cnt), 32'd0);
`endif
        mq.delete();
        m_last  = '0;
        m_stall = 0;
        @(negedge clk);
        i_valid = 1'b0;
        rst     = 1'b0;
        #1;
        check("rst_o_ready", {31'd0, o_ready}, 32'd1);
        @(posedge clk);
        model_edge(1'b0, '0, '0, i_ready, 1'b0);
    endtask

    task automatic idle(input int n, input logic ird);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, ird, 1'b0);
    endtask

    initial begin
        do_reset();

        // Streaming: each word emerges three edges after acceptance.
        for (int n = 1; n <= 5; n++) begin
            cycle(1'b1, 4'hA, 16'(n), 1'b1, 1'b0);
            if (n >= 4) begin
                check("stream_count", 32'(o_count), 32'd3);
            end
        end
        idle(4, 1'b1);

        // Full stall: three accepted, fourth refused until downstream drains.
        for (int n = 1; n <= 3; n++) cycle(1'b1, 4'hA, 16'(n), 1'b0, 1'b0);
        #2;
        check("full_count", 32'(o_count), 32'd3);
        check("full_data", 32'(o_data), 32'h0001);
        cycle(1'b1, 4'hA, 16'h0004, 1'b0, 1'b0);
        cycle(1'b1, 4'hA, 16'h0004, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Bubble collapse: lone stalled entry at the output, two more land behind it.
        cycle(1'b1, 4'h5, 16'h0010, 1'b0, 1'b0);
        idle(2, 1'b0);
        cycle(1'b1, 4'h5, 16'h0011, 1'b0, 1'b0);
        cycle(1'b1, 4'h5, 16'h0012, 1'b0, 1'b0);
        #2;
        check("bubble_count", 32'(o_count), 32'd3);
        check("bubble_data", 32'(o_data), 32'h0010);
        idle(4, 1'b1);

        // Flush a full pipe: control and valids drop, payload held.
        for (int n = 0; n < 3; n++) cycle(1'b1, 4'hF, 16'(16'h0020 + n), 1'b0, 1'b0);
        cycle(1'b1, 4'hF, 16'h0023, 1'b0, 1'b1);
        #2;
        check("flush_valid", {31'd0, o_valid}, 32'd0);
        check("flush_ctrl", 32'(o_ctrl), 32'd0);
        check("flush_count", 32'(o_count), 32'd0);
        check("flush_data", 32'(o_data), 32'h0020);

`ifdef PIPE_STAGE_STALL_CNT_EN
        do_reset();
        cycle(1'b1, 4'h3, 16'h0055, 1'b1, 1'b0);
        idle(2, 1'b1);
        idle(10, 1'b0);
        #2;
        check("stall_cnt_10", 32'(o_stall_cnt), 32'd10);
        cycle(1'b0, '0, '0, 1'b1, 1'b1);
        #2;
        check("stall_cnt_clear", 32'(o_stall_cnt), 32'd10);
        do_reset();
`endif

        // Random traffic with occasional flushes and asynchronous resets.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 16'($urandom),
                      1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
